pixclk_dcm_supervisor: RTL



---
 rtl/pixclk_dcm_supervisor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pixclk_dcm_supervisor.sv
// Pixel-clock DCM supervisor: pulses the DCM reset, waits for lock, checks pix_tick rate per window, retries on failure.
// Async inputs see 2-FF sync (lock: 2 cycles, tick edges: 3 cycles); outputs are registered from next state, no backpressure.
module pixclk_dcm_supervisor #(
  parameter int unsigned C_RESET_CYCLES = 16,
  parameter int unsigned C_LOCK_TIMEOUT = 65536,
  parameter int unsigned C_WINDOW       = 1024,
  parameter int unsigned C_EDGES_MIN    = 40,
  parameter int unsigned C_EDGES_MAX    = 52,
  parameter int unsigned C_MAX_RETRIES  = 7
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pix_tick,
  input  logic       pix_dcm_locked,
  input  logic       restart_req,
  output logic       reset_pixdcm,
  output logic       pix_clk_ok,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned TMAX0 = (C_RESET_CYCLES > C_LOCK_TIMEOUT) ? C_RESET_CYCLES : C_LOCK_TIMEOUT;
  localparam int unsigned TMAX  = (TMAX0 > C_WINDOW) ? TMAX0 : C_WINDOW;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(C_RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(C_LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(C_WINDOW - 1);
  localparam logic [7:0]    EMIN     = 8'(C_EDGES_MIN);
  localparam logic [7:0]    EMAX     = 8'(C_EDGES_MAX);
  localparam logic [4:0]    MAXR     = 5'(C_MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    edge_q, edge_d;
  logic [3:0]    retry_q, retry_d;
  logic [2:0]    tick_q;
  logic [1:0]    lock_q;
  logic          rst_dcm_q, ok_q, fail_q;

  logic       tick_edge, lock_ok, win_end, in_range, failure;
  logic [7:0] edge_sum;
  logic [4:0] retry_inc;

  assign tick_edge = tick_q[1] & ~tick_q[2];
  assign lock_ok   = lock_q[1];
  assign win_end   = (tmr_q == WIN_LAST);
  assign edge_sum  = (edge_q == 8'hFF) ? 8'hFF : edge_q + {7'd0, tick_edge};
  assign in_range  = (edge_sum >= EMIN) && (edge_sum <= EMAX);
  assign retry_inc = {1'b0, retry_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    retry_d = retry_q;
    failure = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (tmr_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
          edge_d  = '0;
        end else if (tmr_q == TO_LAST) begin
          failure = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_MEASURE, ST_RUN: begin
        // Lock loss and a bad count on the same cycle collapse into one failure.
        if (!lock_ok || (win_end && !in_range)) begin
          failure = 1'b1;
        end else if (win_end) begin
          state_d = ST_RUN;
          retry_d = '0;
          tmr_d   = '0;
          edge_d  = '0;
        end else begin
          tmr_d  = tmr_q + TW'(1);
          edge_d = edge_sum;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET;
        tmr_d   = '0;
      end
    endcase

    if (failure) begin
      tmr_d  = '0;
      edge_d = '0;
      if (retry_inc >= MAXR) begin
        state_d = ST_FAIL;
        retry_d = 4'(C_MAX_RETRIES);
      end else begin
        state_d = ST_RESET;
        retry_d = retry_inc[3:0];
      end
    end

    if (restart_req) begin
      state_d = ST_RESET;
      retry_d = '0;
      tmr_d   = '0;
      edge_d  = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_RESET;
      tmr_q     <= '0;
      edge_q    <= '0;
      retry_q   <= '0;
      tick_q    <= '0;
      lock_q    <= '0;
      rst_dcm_q <= 1'b1;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      edge_q    <= edge_d;
      retry_q   <= retry_d;
      tick_q    <= {tick_q[1:0], pix_tick};
      lock_q    <= {lock_q[0], pix_dcm_locked};
      rst_dcm_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      ok_q      <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign reset_pixdcm = rst_dcm_q;
  assign pix_clk_ok   = ok_q;
  assign fail         = fail_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

endmodule
